// File: rtl/ula_seq_ctrl_pkg.sv
// Shared definitions for the ULA operand/opcode sequencer: data width,
// opcode codes and FSM state encodings.
package ula_seq_ctrl_pkg;

  localparam int ULA_W = 4;

  localparam logic [3:0] OP_SOMA = 4'd0;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_NB   = 4'd15;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/ula_seq_ctrl_btn_debounce.sv
// LOAD button conditioning: 2-flop synchroniser, stable-high counter and
// an armed one-shot so a held button yields exactly one pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic ld_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

  logic          sync1;
  logic          lvl;
  logic          armed;
  logic [CW-1:0] cnt;

  // The pulse is visible for the cycle in which the counter sits at its
  // terminal value; the disarm on the following edge keeps it single-cycle.
  assign ld_pulse = armed && (cnt == CNT_MAX);

  // Synchroniser, saturating stable-high counter and re-arm tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      sync1 <= btn;
      lvl   <= sync1;
      if (!lvl)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (!lvl)
        armed <= 1'b1;
      else if (ld_pulse)
        armed <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq_ctrl.sv
// Operand/opcode sequencer in front of the ULA result mux. Loads A, B and
// the opcode from the switch bus on successive LOAD presses, then captures
// the ULA result and flags for display.
//
// state  | meaning
// S_A    | waiting for LOAD to capture operand A
// S_B    | waiting for LOAD to capture operand B
// S_OP   | waiting for LOAD to capture the opcode
// S_EXEC | one clock: latch ULA result, overflow and div-by-zero
// S_DONE | result valid; LOAD starts a new sequence
module ula_seq_ctrl
  import ula_seq_ctrl_pkg::*;
#(
  parameter int W          = ULA_W,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic         btn_load,
  input  logic         btn_clr,
  input  logic [W-1:0] ula_out,
  input  logic         ula_ov,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [3:0]   op,
  output logic [W-1:0] res,
  output logic         res_ov,
  output logic         res_err,
  output logic         res_valid,
  output logic [2:0]   state_o
);

  state_t state;
  state_t state_nx;
  logic   ld_pulse;
  logic   ld_a;
  logic   ld_b;
  logic   ld_op;
  logic   ld_res;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_load),
    .ld_pulse (ld_pulse)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_A;
    else
      state <= state_nx;
  end

  // Next state and register load enables; clear wins and swallows any pulse.
  always_comb begin
    state_nx = state;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    ld_res   = 1'b0;
    if (btn_clr) begin
      state_nx = S_A;
    end else begin
      case (state)
        S_A:    if (ld_pulse) begin ld_a  = 1'b1; state_nx = S_B;    end
        S_B:    if (ld_pulse) begin ld_b  = 1'b1; state_nx = S_OP;   end
        S_OP:   if (ld_pulse) begin ld_op = 1'b1; state_nx = S_EXEC; end
        S_EXEC: begin ld_res = 1'b1; state_nx = S_DONE; end
        S_DONE: if (ld_pulse) state_nx = S_A;
        default: state_nx = S_A;
      endcase
    end
  end

  // Operand and result holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      b       <= '0;
      op      <= '0;
      res     <= '0;
      res_ov  <= 1'b0;
      res_err <= 1'b0;
    end else if (btn_clr) begin
      a       <= '0;
      b       <= '0;
      op      <= '0;
      res     <= '0;
      res_ov  <= 1'b0;
      res_err <= 1'b0;
    end else begin
      if (ld_a)  a  <= sw;
      if (ld_b)  b  <= sw;
      if (ld_op) op <= sw[3:0];
      if (ld_res) begin
        res     <= ula_out;
        res_ov  <= ula_ov;
        res_err <= (op == OP_DIV) && (b == '0);
      end
    end
  end

  assign res_valid = (state == S_DONE);
  assign state_o   = state;

endmodule
